// File: rtl/sigpulse_pkg.sv
// Shared definitions for the sigpulse family: receiver FSM encoding and the
// synchronizer depth used on every asynchronous pulse input.
package sigpulse_pkg;

    localparam int SIGPULSE_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        MEAS_IDLE     = 2'd0,
        MEAS_WAIT_DEF = 2'd1,
        MEAS_ARMED    = 2'd2,
        MEAS_COUNT    = 2'd3
    } meas_state_e;

endpackage

// File: rtl/sigpulse_infilt.sv
// Input conditioning for sigpulse_meas: synchronizer followed by an optional
// glitch filter enabled with SIGPULSE_MEAS_FILTER_EN.
module sigpulse_infilt
    import sigpulse_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic io_clk,
    input  logic io_rst_n,
    input  logic din,
    output logic dout
);

    logic [SIGPULSE_SYNC_STAGES-1:0] sync_q;
    logic                            syncOut;

    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SIGPULSE_SYNC_STAGES-2:0], din};
        end
    end

    assign syncOut = sync_q[SIGPULSE_SYNC_STAGES-1];

`ifdef SIGPULSE_MEAS_FILTER_EN
    localparam logic [7:0] FiltLast = 8'(FILT_LEN - 1);

    logic [7:0] filtCnt_q;
    logic       filt_q;

    // Both edges see the same FILT_LEN delay, so pulse widths are preserved.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            filtCnt_q <= '0;
            filt_q    <= 1'b0;
        end else if (syncOut == filt_q) begin
            filtCnt_q <= '0;
        end else if (filtCnt_q == FiltLast) begin
            filtCnt_q <= '0;
            filt_q    <= syncOut;
        end else begin
            filtCnt_q <= filtCnt_q + 8'd1;
        end
    end

    assign dout = filt_q;
`else
    assign dout = syncOut;
`endif

endmodule

// File: rtl/sigpulse_meas.sv
// Pulse-width receiver: measures one complete active pulse on io_pulseIn in
// io_clk cycles. Optional glitch filter: SIGPULSE_MEAS_FILTER_EN.
module sigpulse_meas
    import sigpulse_pkg::*;
#(
    parameter int _RAM_WIDTH = 32,
    parameter int FILT_LEN   = 4
) (
    input  logic                   io_clk,
    input  logic                   io_rst_n,
    input  logic                   io_en,
    input  logic                   meas_dis,
    input  logic                   io_defaultLevel,
    input  logic                   io_pulseIn,
    output logic [_RAM_WIDTH-1:0]  io_widthOut,
    output logic                   pulse_valid,
    output logic                   io_overflow,
    output logic                   io_busy
);

    localparam logic [_RAM_WIDTH-1:0] CntMax = '1;
    localparam logic [_RAM_WIDTH-1:0] CntOne = {{(_RAM_WIDTH-1){1'b0}}, 1'b1};

    meas_state_e             state_q;
    logic                    lvl;
    logic                    act;
    logic                    def_q;
    logic [_RAM_WIDTH-1:0]   cnt_q;
    logic [_RAM_WIDTH-1:0]   cnt_d;
    logic                    cntSat;
    logic                    ovf_q;
    logic [_RAM_WIDTH-1:0]   widthOut_q;
    logic                    valid_q;
    logic                    overflow_q;

    sigpulse_infilt #(
        .FILT_LEN(FILT_LEN)
    ) u_infilt (
        .io_clk  (io_clk),
        .io_rst_n(io_rst_n),
        .din     (io_pulseIn),
        .dout    (lvl)
    );

    assign act    = lvl ^ def_q;
    assign cntSat = (cnt_q == CntMax);
    assign cnt_d  = cntSat ? cnt_q : (cnt_q + CntOne);

    // WAIT_DEF exists so that arming in the middle of a pulse never reports a truncated width.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            state_q    <= MEAS_IDLE;
            def_q      <= 1'b0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            widthOut_q <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (meas_dis) begin
                state_q <= MEAS_IDLE;
            end else begin
                case (state_q)
                    MEAS_IDLE: begin
                        if (io_en) begin
                            def_q   <= io_defaultLevel;
                            cnt_q   <= '0;
                            ovf_q   <= 1'b0;
                            state_q <= MEAS_WAIT_DEF;
                        end
                    end
                    MEAS_WAIT_DEF: begin
                        if (!act) begin
                            state_q <= MEAS_ARMED;
                        end
                    end
                    MEAS_ARMED: begin
                        if (act) begin
                            cnt_q   <= CntOne;
                            state_q <= MEAS_COUNT;
                        end
                    end
                    MEAS_COUNT: begin
                        if (act) begin
                            cnt_q <= cnt_d;
                            if (cntSat) begin
                                ovf_q <= 1'b1;
                            end
                        end else begin
                            widthOut_q <= cnt_q;
                            overflow_q <= ovf_q;
                            valid_q    <= 1'b1;
                            state_q    <= MEAS_IDLE;
                        end
                    end
                    default: begin
                        state_q <= MEAS_IDLE;
                    end
                endcase
            end
        end
    end

    assign io_widthOut = widthOut_q;
    assign pulse_valid = valid_q;
    assign io_overflow = overflow_q;
    assign io_busy     = (state_q != MEAS_IDLE);

endmodule

// File: tb/tb_sigpulse_meas.sv
// Directed self-checking bench for sigpulse_meas; a second, 4-bit-wide
// instance shares the stimulus to exercise counter saturation.
module tb_sigpulse_meas;

    localparam int FILT_LEN = 4;
`ifdef SIGPULSE_MEAS_FILTER_EN
    localparam int LAT = 3 + FILT_LEN;
`else
    localparam int LAT = 3;
`endif

    logic        clk;
    logic        rstN;
    logic        en;
    logic        measDis;
    logic        defaultLevel;
    logic        pulseIn;
    logic [31:0] widthOut;
    logic        pulseValid;
    logic        overflow;
    logic        busy;
    logic [3:0]  narrowWidth;
    logic        narrowValid;
    logic        narrowOverflow;
    logic        narrowBusy;

    int assertCount = 0;
    int failCount   = 0;
    int validCount  = 0;
    int base        = 0;

    sigpulse_meas #(
        ._RAM_WIDTH(32),
        .FILT_LEN  (FILT_LEN)
    ) dut (
        .io_clk         (clk),
        .io_rst_n       (rstN),
        .io_en          (en),
        .meas_dis       (measDis),
        .io_defaultLevel(defaultLevel),
        .io_pulseIn     (pulseIn),
        .io_widthOut    (widthOut),
        .pulse_valid    (pulseValid),
        .io_overflow    (overflow),
        .io_busy        (busy)
    );

    sigpulse_meas #(
        ._RAM_WIDTH(4),
        .FILT_LEN  (FILT_LEN)
    ) dutNarrow (
        .io_clk         (clk),
        .io_rst_n       (rstN),
        .io_en          (en),
        .meas_dis       (measDis),
        .io_defaultLevel(defaultLevel),
        .io_pulseIn     (pulseIn),
        .io_widthOut    (narrowWidth),
        .pulse_valid    (narrowValid),
        .io_overflow    (narrowOverflow),
        .io_busy        (narrowBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobes are counted one edge late so the stimulus process never races the count.
    always @(posedge clk) begin
        if (pulseValid) validCount++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic level, input int n);
        pulseIn = level;
        waitCycles(n);
    endtask

    task automatic armOnce();
        en = 1'b1;
        waitCycles(1);
        en = 1'b0;
    endtask

    task automatic measurePulse(input string tag, input logic active, input int w);
        applyStimulus(active, w);
        pulseIn = ~active;
        waitCycles(LAT - 1);
        checkOutput({tag, "_validEarly"}, 32'(pulseValid), 32'd0);
        waitCycles(1);
        checkOutput({tag, "_valid"}, 32'(pulseValid), 32'd1);
        checkOutput({tag, "_width"}, widthOut, 32'(w));
        checkOutput({tag, "_ovf"}, 32'(overflow), 32'd0);
        checkOutput({tag, "_busyLow"}, 32'(busy), 32'd0);
        waitCycles(1);
        checkOutput({tag, "_validOneCycle"}, 32'(pulseValid), 32'd0);
    endtask

    initial begin
        rstN         = 1'b0;
        en           = 1'b0;
        measDis      = 1'b0;
        defaultLevel = 1'b1;
        pulseIn      = 1'b1;
        waitCycles(3);
        checkOutput("rstWidth", widthOut, 32'd0);
        checkOutput("rstValid", 32'(pulseValid), 32'd0);
        checkOutput("rstOvf", 32'(overflow), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        rstN = 1'b1;
        waitCycles(4);

        $display("[TB] basic 1000-cycle low pulse");
        base = validCount;
        armOnce();
        checkOutput("armBusy", 32'(busy), 32'd1);
        waitCycles(4);
        measurePulse("w1000", 1'b0, 1000);
        checkOutput("w1000_count", 32'(validCount), 32'(base + 1));

        $display("[TB] arm during active level");
        pulseIn = 1'b0;
        waitCycles(10);
        base = validCount;
        armOnce();
        applyStimulus(1'b0, 300);
        applyStimulus(1'b1, 10);
        measurePulse("partial", 1'b0, 50);
        checkOutput("partial_count", 32'(validCount), 32'(base + 1));

        $display("[TB] abort mid-pulse");
        base = validCount;
        armOnce();
        waitCycles(4);
        applyStimulus(1'b0, 50);
        measDis = 1'b1;
        waitCycles(1);
        measDis = 1'b0;
        checkOutput("disBusy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 49);
        pulseIn = 1'b1;
        waitCycles(LAT + 3);
        checkOutput("disNoReport", 32'(validCount), 32'(base));
        checkOutput("disWidthHeld", widthOut, 32'd50);

        en      = 1'b1;
        measDis = 1'b1;
        waitCycles(1);
        en      = 1'b0;
        measDis = 1'b0;
        checkOutput("disBeatsEn", 32'(busy), 32'd0);

        $display("[TB] default level latched on arm");
        defaultLevel = 1'b0;
        pulseIn      = 1'b0;
        waitCycles(4);
        armOnce();
        defaultLevel = 1'b1;
        waitCycles(4);
        measurePulse("defLatch", 1'b1, 30);
        pulseIn = 1'b1;
        waitCycles(4);

        $display("[TB] saturation on narrow instance");
        armOnce();
        waitCycles(4);
        measurePulse("w40", 1'b0, 40);
        checkOutput("narrowWidth", 32'(narrowWidth), 32'd15);
        checkOutput("narrowOvf", 32'(narrowOverflow), 32'd1);

        $display("[TB] short glitch");
        armOnce();
        waitCycles(4);
        base = validCount;
        applyStimulus(1'b0, 3);
        pulseIn = 1'b1;
        waitCycles(LAT + 5);
`ifdef SIGPULSE_MEAS_FILTER_EN
        checkOutput("glitchNoReport", 32'(validCount), 32'(base));
        checkOutput("glitchStillArmed", 32'(busy), 32'd1);
`else
        checkOutput("glitchReport", 32'(validCount), 32'(base + 1));
        checkOutput("glitchWidth", widthOut, 32'd3);
        armOnce();
        waitCycles(4);
`endif
        measurePulse("w20", 1'b0, 20);

        $display("[TB] back-to-back with io_en held");
        en = 1'b1;
        waitCycles(4);
        base = validCount;
        for (int i = 0; i < 2; i++) begin
            measurePulse("loop", 1'b0, 1000);
            waitCycles(3);
        end
        checkOutput("loopCount", 32'(validCount), 32'(base + 2));
        en = 1'b0;
        waitCycles(4);

        $display("[TB] reset mid-pulse");
        armOnce();
        waitCycles(4);
        base = validCount;
        applyStimulus(1'b0, 100);
        rstN = 1'b0;
        #1;
        checkOutput("midRstWidth", widthOut, 32'd0);
        checkOutput("midRstValid", 32'(pulseValid), 32'd0);
        checkOutput("midRstOvf", 32'(overflow), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        waitCycles(2);
        rstN = 1'b1;
        applyStimulus(1'b0, 100);
        pulseIn = 1'b1;
        waitCycles(LAT + 3);
        checkOutput("postRstNoReport", 32'(validCount), 32'(base));
        checkOutput("postRstWidth", widthOut, 32'd0);
        armOnce();
        waitCycles(4);
        measurePulse("postRst", 1'b0, 25);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
